frame_stream_loader: RTL and testbench

- Upstream stage of the iterative scaling top. Accepts a byte-wide AXI-Stream-style frame from the host/DMA and assembles two kinds of word:
  - I rows of the binary H matrix, J bits each.
  - A columns of alpha_u, J×8 bits each.
- Each assembled word is emitted as a single-cycle tvalid pulse, with tlast marking the last row and the last column.
- Its outputs connect directly to the top's H_row* and alpha_u_col* inputs; that top has no ready signal, so this block never waits on downstream.

---
 rtl/frame_stream_loader.sv | 214 +++++++++++++++++++++
 tb/tb_frame_stream_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_loader.sv
// frame_stream_loader: turns a byte-wide AXI-Stream frame into I rows of the H matrix
// (J bits each) followed by A alpha_u columns (J bytes each). Every finished word is
// published one cycle after its last byte is accepted, as a single-cycle tvalid pulse.
// There is no downstream ready: the block never waits on its consumer.
// Optional feature: define LOADER_TLAST_CHECK_EN to check s_axis_tlast against the
// expected final byte, with a sticky frame_err and a drain state for over-long frames.
module frame_stream_loader #(
    parameter int unsigned J = 14,
    parameter int unsigned I = 7,
    parameter int unsigned A = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     s_axis_tdata,
    input  logic           s_axis_tvalid,
    input  logic           s_axis_tlast,
    output logic           s_axis_tready,
    input  logic           hold,
    output logic [J-1:0]   H_row,
    output logic           H_row_tvalid,
    output logic           H_row_tlast,
    output logic [J*8-1:0] alpha_u_col,
    output logic           alpha_u_col_tvalid,
    output logic           alpha_u_col_tlast,
    output logic           frame_done,
    output logic           frame_err
);

    localparam int unsigned HB = (J + 7) / 8;
    localparam int unsigned BW = $clog2(J + 1);
    localparam int unsigned RW = $clog2(I + 1);
    localparam int unsigned CW = $clog2(A + 1);

    typedef enum logic [1:0] {
`ifdef LOADER_TLAST_CHECK_EN
        StH,
        StA,
        StDrain
`else
        StH,
        StA
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [RW-1:0]   row_cnt_q, row_cnt_d;
    logic [CW-1:0]   col_cnt_q, col_cnt_d;
    logic [HB*8-1:0] row_buf_q, row_asm;
    logic [J*8-1:0]  col_buf_q, col_asm;
    logic [J-1:0]    h_row_q;
    logic [J*8-1:0]  alpha_q;
    logic            h_valid_q, h_last_q, a_valid_q, a_last_q;
    logic            h_pulse, h_last, a_pulse, a_last;
    logic            accept;

    assign s_axis_tready = !hold;
    assign accept        = s_axis_tvalid && !hold;

`ifdef LOADER_TLAST_CHECK_EN
    logic err_q, err_set;
    assign frame_err = err_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign frame_err    = 1'b0;
`endif

    // Merge the incoming byte into the current row / column image at byte_cnt.
    always_comb begin
        row_asm = row_buf_q;
        col_asm = col_buf_q;
        for (int k = 0; k < HB; k++) begin
            if (byte_cnt_q == BW'(k)) row_asm[k*8+:8] = s_axis_tdata;
        end
        for (int k = 0; k < J; k++) begin
            if (byte_cnt_q == BW'(k)) col_asm[k*8+:8] = s_axis_tdata;
        end
    end

    // Next-state, counters and word-complete strobes.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        row_cnt_d  = row_cnt_q;
        col_cnt_d  = col_cnt_q;
        h_pulse    = 1'b0;
        h_last     = 1'b0;
        a_pulse    = 1'b0;
        a_last     = 1'b0;
`ifdef LOADER_TLAST_CHECK_EN
        err_set    = 1'b0;
`endif
        if (accept) begin
            unique case (state_q)
                StH: begin
                    if (byte_cnt_q == BW'(HB - 1)) begin
                        byte_cnt_d = '0;
                        h_pulse    = 1'b1;
                        h_last     = (row_cnt_q == RW'(I - 1));
                        if (row_cnt_q == RW'(I - 1)) begin
                            row_cnt_d = '0;
                            state_d   = StA;
                        end else begin
                            row_cnt_d = row_cnt_q + RW'(1);
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
`ifdef LOADER_TLAST_CHECK_EN
                    // tlast can never be legal here: abort the frame, drop the word.
                    if (s_axis_tlast) begin
                        err_set    = 1'b1;
                        h_pulse    = 1'b0;
                        h_last     = 1'b0;
                        byte_cnt_d = '0;
                        row_cnt_d  = '0;
                        col_cnt_d  = '0;
                        state_d    = StH;
                    end
`endif
                end
                StA: begin
                    if (byte_cnt_q == BW'(J - 1)) begin
                        byte_cnt_d = '0;
                        a_pulse    = 1'b1;
                        a_last     = (col_cnt_q == CW'(A - 1));
                        if (col_cnt_q == CW'(A - 1)) begin
                            col_cnt_d = '0;
                            state_d   = StH;
                        end else begin
                            col_cnt_d = col_cnt_q + CW'(1);
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
`ifdef LOADER_TLAST_CHECK_EN
                    if (s_axis_tlast && !a_last) begin
                        err_set    = 1'b1;
                        a_pulse    = 1'b0;
                        byte_cnt_d = '0;
                        row_cnt_d  = '0;
                        col_cnt_d  = '0;
                        state_d    = StH;
                    end else if (a_last && !s_axis_tlast) begin
                        // Final word still goes out; skip the rest of the over-long frame.
                        err_set = 1'b1;
                        state_d = StDrain;
                    end
`endif
                end
`ifdef LOADER_TLAST_CHECK_EN
                StDrain: begin
                    if (s_axis_tlast) state_d = StH;
                end
`endif
                default: state_d = StH;
            endcase
        end
    end

    // FSM state, counters and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StH;
            byte_cnt_q <= '0;
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
`ifdef LOADER_TLAST_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            row_cnt_q  <= row_cnt_d;
            col_cnt_q  <= col_cnt_d;
`ifdef LOADER_TLAST_CHECK_EN
            err_q      <= err_q | err_set;
`endif
        end
    end

    // Assembly buffers, held output words and one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_buf_q <= '0;
            col_buf_q <= '0;
            h_row_q   <= '0;
            alpha_q   <= '0;
            h_valid_q <= 1'b0;
            h_last_q  <= 1'b0;
            a_valid_q <= 1'b0;
            a_last_q  <= 1'b0;
        end else begin
            if (accept && state_q == StH) row_buf_q <= row_asm;
            if (accept && state_q == StA) col_buf_q <= col_asm;
            if (h_pulse) h_row_q <= row_asm[J-1:0];
            if (a_pulse) alpha_q <= col_asm;
            h_valid_q <= h_pulse;
            h_last_q  <= h_last;
            a_valid_q <= a_pulse;
            a_last_q  <= a_last;
        end
    end

    assign H_row              = h_row_q;
    assign H_row_tvalid       = h_valid_q;
    assign H_row_tlast        = h_last_q;
    assign alpha_u_col        = alpha_q;
    assign alpha_u_col_tvalid = a_valid_q;
    assign alpha_u_col_tlast  = a_last_q;
    assign frame_done         = a_last_q;

endmodule

// File: tb/tb_frame_stream_loader.sv
// Testbench for frame_stream_loader: a frame-position model predicts every output on
// every cycle; literal checks after each scenario pin the model to known values.
module tb_frame_stream_loader;

    localparam int J  = 14;
    localparam int I  = 7;
    localparam int A  = 2;
    localparam int HB = (J + 7) / 8;
    localparam int FL = I * HB + A * J;
`ifdef LOADER_TLAST_CHECK_EN
    localparam bit TLCHK = 1'b1;
`else
    localparam bit TLCHK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     s_axis_tdata = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tlast = 1'b0;
    logic           s_axis_tready;
    logic           hold = 1'b0;
    logic [J-1:0]   H_row;
    logic           H_row_tvalid, H_row_tlast;
    logic [J*8-1:0] alpha_u_col;
    logic           alpha_u_col_tvalid, alpha_u_col_tlast;
    logic           frame_done, frame_err;

    frame_stream_loader #(.J(J), .I(I), .A(A)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tready      (s_axis_tready),
        .hold               (hold),
        .H_row              (H_row),
        .H_row_tvalid       (H_row_tvalid),
        .H_row_tlast        (H_row_tlast),
        .alpha_u_col        (alpha_u_col),
        .alpha_u_col_tvalid (alpha_u_col_tvalid),
        .alpha_u_col_tlast  (alpha_u_col_tlast),
        .frame_done         (frame_done),
        .frame_err          (frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Model state: position within the frame plus expected registered outputs.
    int             m_pos = 0;
    bit             m_drain = 1'b0;
    bit             m_err = 1'b0;
    logic [7:0]     m_buf [FL];
    logic           exp_hv = 0, exp_hl = 0, exp_av = 0, exp_al = 0;
    logic [J-1:0]   exp_row = '0;
    logic [J*8-1:0] exp_col = '0;

    // Observed pulses, for literal checks.
    logic [J-1:0]   h_obs [16];
    logic [J*8-1:0] a_obs [4];
    int             n_h = 0, n_a = 0, n_done = 0;
    logic [15:0]    h_last_mask = '0;
    logic [3:0]     a_last_mask = '0;

    task automatic clear_obs();
        n_h = 0; n_a = 0; n_done = 0; h_last_mask = '0; a_last_mask = '0;
    endtask

    // Compare every cycle, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        chk("tready", s_axis_tready, !hold);
        if (!rst_n) begin
            m_pos = 0; m_drain = 0; m_err = 0;
            exp_hv = 0; exp_hl = 0; exp_av = 0; exp_al = 0;
            exp_row = '0; exp_col = '0;
            chk("rst_pulses", {H_row_tvalid, H_row_tlast, alpha_u_col_tvalid,
                               alpha_u_col_tlast, frame_done, frame_err}, '0);
            chk("rst_data", {H_row, alpha_u_col}, '0);
        end else begin
            chk("h_valid", H_row_tvalid, exp_hv);
            chk("h_last", H_row_tlast, exp_hl);
            chk("h_row", H_row, exp_row);
            chk("a_valid", alpha_u_col_tvalid, exp_av);
            chk("a_last", alpha_u_col_tlast, exp_al);
            chk("a_col", alpha_u_col, exp_col);
            chk("done", frame_done, exp_al);
            chk("err", frame_err, m_err);
            if (H_row_tvalid) begin
                if (n_h < 16) h_obs[n_h] = H_row;
                if (H_row_tlast && n_h < 16) h_last_mask[n_h] = 1'b1;
                n_h++;
            end
            if (alpha_u_col_tvalid) begin
                if (n_a < 4) a_obs[n_a] = alpha_u_col;
                if (alpha_u_col_tlast && n_a < 4) a_last_mask[n_a] = 1'b1;
                n_a++;
            end
            if (frame_done) n_done++;

            exp_hv = 0; exp_hl = 0; exp_av = 0; exp_al = 0;
            if (s_axis_tvalid && !hold) begin
                if (m_drain) begin
                    if (s_axis_tlast) m_drain = 0;
                end else begin
                    m_buf[m_pos] = s_axis_tdata;
                    if (TLCHK && s_axis_tlast && m_pos != FL - 1) begin
                        m_err = 1; m_pos = 0;
                    end else begin
                        if (m_pos < I * HB) begin
                            if (m_pos % HB == HB - 1) begin
                                logic [HB*8-1:0] tmp;
                                int r;
                                r = m_pos / HB;
                                for (int k = 0; k < HB; k++) tmp[k*8+:8] = m_buf[r*HB+k];
                                exp_row = tmp[J-1:0];
                                exp_hv = 1; exp_hl = (r == I - 1);
                            end
                        end else if ((m_pos - I * HB) % J == J - 1) begin
                            int c;
                            c = (m_pos - I * HB) / J;
                            for (int k = 0; k < J; k++) exp_col[k*8+:8] = m_buf[I*HB+c*J+k];
                            exp_av = 1; exp_al = (c == A - 1);
                        end
                        m_pos++;
                        if (m_pos == FL) begin
                            m_pos = 0;
                            if (TLCHK && !s_axis_tlast) begin m_err = 1; m_drain = 1; end
                        end
                    end
                end
            end
        end
    end

    function automatic logic [7:0] fbyte(input int kind, input int p);
        if (p < I * HB) return (kind == 1) ? 8'hFF : 8'(p + 1);
        return 8'(16 * ((p - I * HB) / J) + (p - I * HB) % J + 1);
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic last, input bit gaps);
        bit done = 0;
        int tries = 0;
        s_axis_tdata = b;
        s_axis_tlast = last;
        while (!done) begin
            if (gaps && tries < 40) begin
                s_axis_tvalid = ($urandom_range(0, 2) != 0);
                hold          = ($urandom_range(0, 3) == 0);
            end else begin
                s_axis_tvalid = 1'b1;
                hold          = 1'b0;
            end
            @(posedge clk);
            done = s_axis_tvalid && !hold;
            #1;
            tries++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int kind, input bit gaps, input int n, input int tl);
        for (int p = 0; p < n; p++) send_byte(fbyte(kind, p), (p == tl), gaps);
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_std_frame(input string tag);
        chk({tag, "_nh"}, n_h, 7);
        chk({tag, "_na"}, n_a, 2);
        chk({tag, "_ndone"}, n_done, 1);
        chk({tag, "_row0"}, h_obs[0], 14'h0201);
        chk({tag, "_row6"}, h_obs[6], 14'h0E0D);
        chk({tag, "_hlast"}, h_last_mask, 16'h0040);
        chk({tag, "_c1b0"}, a_obs[1][7:0], 8'h11);
        chk({tag, "_c0b13"}, a_obs[0][111:104], 8'h0E);
        chk({tag, "_alast"}, a_last_mask, 4'b0010);
    endtask

    initial begin
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        idle(2);

        // Clean frame, no gaps.
        clear_obs();
        send_frame(0, 0, FL, FL - 1);
        idle(3);
        chk_std_frame("clean");
        chk("clean_err", frame_err, 1'b0);

        // Same frame with random gaps and hold toggling.
        clear_obs();
        send_frame(0, 1, FL, FL - 1);
        hold = 1'b0;
        idle(3);
        chk_std_frame("gaps");

        // All-ones H bytes: bits 14/15 dropped.
        clear_obs();
        send_frame(1, 0, FL, FL - 1);
        idle(3);
        chk("ones_row0", h_obs[0], 14'h3FFF);
        chk("ones_nh", n_h, 7);

        // Two frames back to back.
        clear_obs();
        send_frame(0, 0, FL, FL - 1);
        send_frame(0, 0, FL, FL - 1);
        idle(3);
        chk("b2b_nh", n_h, 14);
        chk("b2b_ndone", n_done, 2);
        chk("b2b_row7", h_obs[7], 14'h0201);
        chk("b2b_hlast", h_last_mask, 16'h2040);

        // Reset after byte 20, then a full frame.
        clear_obs();
        send_frame(0, 0, 20, -1);
        idle(1);
        chk("mid_nh", n_h, 7);
        chk("mid_na", n_a, 0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        clear_obs();
        send_frame(0, 0, FL, FL - 1);
        idle(3);
        chk_std_frame("postrst");

`ifdef LOADER_TLAST_CHECK_EN
        // Early tlast on byte 9.
        clear_obs();
        send_frame(0, 0, 9, 8);
        idle(2);
        chk("early_nh", n_h, 4);
        chk("early_err", frame_err, 1'b1);
        clear_obs();
        send_frame(0, 0, FL, FL - 1);
        idle(3);
        chk_std_frame("after_early");
        chk("early_sticky", frame_err, 1'b1);

        // Missing tlast, then 3 extra bytes drained.
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        clear_obs();
        send_frame(0, 0, FL, -1);
        idle(2);
        chk("late_na", n_a, 2);
        chk("late_err", frame_err, 1'b1);
        send_frame(0, 0, 3, 2);
        clear_obs();
        send_frame(0, 0, FL, FL - 1);
        idle(3);
        chk_std_frame("after_drain");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
